// File: rtl/mul_acc_pkg.sv
// Shared widths for the shift-add multiplier and its block accumulator.
package mul_acc_pkg;

  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

  localparam int unsigned N_DEF   = 32'd4;
  localparam int unsigned LEN_DEF = 32'd4;
  localparam int unsigned PROD_W  = 32'd2 * N_DEF;
  localparam int unsigned LOG2LEN = clog2_f(LEN_DEF);
  localparam int unsigned ACC_W   = PROD_W + LOG2LEN;

endpackage

// File: rtl/mul_acc_if.sv
// Product input stream and block-sum output stream of the accumulator.
interface mul_acc_if import mul_acc_pkg::*; #(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned LEN = LEN_DEF
);
  localparam int unsigned PW = 32'd2 * N;
  localparam int unsigned AW = PW + clog2_f(LEN);

  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          clear;
  logic          in_ready;
  logic [AW-1:0] out_sum;
  logic          out_valid;
  logic          out_ready;
  logic          drop_err;

  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_sum, out_valid, drop_err
  );

  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_sum, out_valid, drop_err
  );
endinterface

// File: rtl/mul_acc_outreg.sv
// Block-sum holding register with valid/ready handshake and sticky drop flag.
module mul_acc_outreg #(
  parameter int unsigned W = 32'd10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_valid,
  output logic         drop_err,
  output logic         busy
);
  logic [W-1:0] out_sum_d, out_sum_q;
  logic         out_valid_d, out_valid_q;
  logic         drop_err_d, drop_err_q;

  assign busy      = out_valid_q && !out_ready;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign drop_err  = drop_err_q;

  // A load into a free register wins over the handshake clearing out_valid.
  always_comb begin
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    drop_err_d  = drop_err_q;
    if (load && !busy) begin
      out_sum_d   = load_data;
      out_valid_d = 1'b1;
    end else if (load) begin
      drop_err_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum_q   <= {W{1'b0}};
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
    end
  end
endmodule

// File: rtl/mul_acc.sv
// Sums LEN consecutive multiplier products into one block sum.
// Define MUL_ACC_AVG_EN to present the truncated block mean instead of the sum.
module mul_acc import mul_acc_pkg::*; #(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned LEN = LEN_DEF
) (
  input  logic     clk,
  input  logic     rst,
  mul_acc_if.slave bus
);
  localparam int unsigned PW = 32'd2 * N;
  localparam int unsigned LW = clog2_f(LEN);
  localparam int unsigned AW = PW + LW;
  localparam logic [LW-1:0] CNT_LAST = LW'(LEN - 32'd1);
  localparam logic [LW-1:0] CNT_ONE  = LW'(32'd1);

  logic [AW-1:0] acc_d, acc_q;
  logic [LW-1:0] cnt_d, cnt_q;
  logic [AW-1:0] blk_sum_s;
  logic [AW-1:0] load_data_s;
  logic          last_beat_s;
  logic          out_busy_s;

  assign blk_sum_s = acc_q + AW'(bus.in_data);

`ifdef MUL_ACC_AVG_EN
  assign load_data_s = blk_sum_s >> LW;
`else
  assign load_data_s = blk_sum_s;
`endif

  // clear suppresses a coincident product, including a last beat.
  assign last_beat_s  = bus.in_valid && !bus.clear && (cnt_q == CNT_LAST);
  assign bus.in_ready = !((cnt_q == CNT_LAST) && out_busy_s);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.clear) begin
      acc_d = {AW{1'b0}};
      cnt_d = {LW{1'b0}};
    end else if (bus.in_valid && (cnt_q == CNT_LAST)) begin
      acc_d = {AW{1'b0}};
      cnt_d = {LW{1'b0}};
    end else if (bus.in_valid) begin
      acc_d = blk_sum_s;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {AW{1'b0}};
      cnt_q <= {LW{1'b0}};
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  mul_acc_outreg #(.W(AW)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (last_beat_s),
    .load_data (load_data_s),
    .out_ready (bus.out_ready),
    .out_sum   (bus.out_sum),
    .out_valid (bus.out_valid),
    .drop_err  (bus.drop_err),
    .busy      (out_busy_s)
  );
endmodule

// File: tb/tb_mul_acc.sv
// Scoreboard bench for mul_acc: directed scenarios followed by random traffic.
module tb_mul_acc;
  localparam int TN   = 4;
  localparam int TLEN = 4;
  localparam int PW   = 2 * TN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_acc_if #(.N(TN), .LEN(TLEN)) bus ();
  mul_acc #(.N(TN), .LEN(TLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Reference: products of the open block, expected sums awaiting delivery.
  int blk[$];
  int exp_q[$];
  bit m_valid, m_drop;
  bit e_valid, e_drop, e_in_ready;
  bit mon_en;
  int n_checks, n_pass;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int expv(input int s);
`ifdef MUL_ACC_AVG_EN
    return s / TLEN;
`else
    return s;
`endif
  endfunction

  task automatic step(input bit iv, input int d, input bit clr, input bit ordy, input bit r);
    bit hs;
    bit load;
    int sum;
    @(posedge clk);
    #1;
    e_valid    = m_valid;
    e_drop     = m_drop;
    e_in_ready = !((blk.size() == TLEN - 1) && m_valid && !ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = PW'(d);
    bus.clear     = clr;
    bus.out_ready = ordy;
    if (r) begin
      blk.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_drop  = 1'b0;
    end else begin
      mon_en = 1'b1;
      hs   = m_valid && ordy;
      load = 1'b0;
      if (clr) begin
        blk.delete();
      end else if (iv) begin
        blk.push_back(d);
        if (blk.size() == TLEN) begin
          sum = 0;
          foreach (blk[i]) sum += blk[i];
          blk.delete();
          if (!m_valid || ordy) begin
            load = 1'b1;
            exp_q.push_back(expv(sum));
          end else begin
            m_drop = 1'b1;
          end
        end
      end
      if (load) m_valid = 1'b1;
      else if (hs) m_valid = 1'b0;
    end
  endtask

  task automatic feed(input int d, input bit ordy);
    step(1'b1, d, 1'b0, ordy, 1'b0);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: compares every presented sum and the handshake flags.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("out_valid", bus.out_valid, e_valid);
      check("drop_err", bus.drop_err, e_drop);
      check("in_ready", bus.in_ready, e_in_ready);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: out_valid=1 out_sum=%0d with no expected sum", bus.out_sum);
        end else begin
          check("out_sum", bus.out_sum, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    mon_en = 1'b0; n_checks = 0; n_pass = 0; m_valid = 1'b0; m_drop = 1'b0;

    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1'b1); #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_drop_err", bus.drop_err, 0);
    check("rst_in_ready", bus.in_ready, 1);

    feed(15, 1'b1); feed(225, 1'b1); feed(1, 1'b1); feed(0, 1'b1);
    idle(1'b1); #1;
    check("blk241_valid", bus.out_valid, 1);
    check("blk241_sum", bus.out_sum, expv(241));

    for (int i = 0; i < 4; i++) feed(225, 1'b1);
    idle(1'b1); #1;
    check("blk900_sum", bus.out_sum, expv(900));

    // Held output, next block is dropped.
    feed(15, 1'b0); feed(225, 1'b0); feed(1, 1'b0); feed(0, 1'b0);
    feed(1, 1'b0); feed(1, 1'b0); feed(1, 1'b0);
    idle(1'b0); #1;
    check("busy_in_ready", bus.in_ready, 0);
    feed(1, 1'b0);
    idle(1'b0); #1;
    check("drop_err_set", bus.drop_err, 1);
    check("drop_sum_kept", bus.out_sum, expv(241));
    idle(1'b1);
    idle(1'b0); #1;
    check("drop_hs_valid", bus.out_valid, 0);

    // Handshake coincides with the next last beat.
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) feed(2, 1'b0);
    for (int i = 0; i < 3; i++) feed(3, 1'b0);
    feed(3, 1'b1);
    idle(1'b0); #1;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_sum", bus.out_sum, expv(12));
    check("b2b_no_drop", bus.drop_err, 0);
    idle(1'b1);

    // clear aborts a partial block and beats a coincident product.
    feed(100, 1'b1); feed(100, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) feed(10, 1'b1);
    idle(1'b1); #1;
    check("clear_sum", bus.out_sum, expv(40));
    feed(5, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) feed(5, 1'b1);
    idle(1'b1); #1;
    check("clear_iv_sum", bus.out_sum, expv(20));

    // Reset mid-block with a held sum and a raised error.
    for (int i = 0; i < 8; i++) feed(1, 1'b0);
    feed(1, 1'b0); feed(1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1'b0); #1;
    check("rst2_out_valid", bus.out_valid, 0);
    check("rst2_out_sum", bus.out_sum, 0);
    check("rst2_drop_err", bus.drop_err, 0);
    check("rst2_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 3000; i++) begin
      int d;
      d = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) d = 255;
      step($urandom_range(0, 1) == 1, d, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    #1;
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mul_acc.md
Name: mul_acc

Overview:
- Downstream stage of the shift-add multiplier: consumes its 2N-bit product and single-cycle valid pulse.
- Sums LEN consecutive products into one block sum and presents it on a valid/ready output.
- Provides in_ready so the control logic gates the multiplier's start, and a sticky error when a block sum would otherwise be lost.

Parameters:
- N, 4, multiplier operand width; products are 2N bits.
- LEN, 4, number of products per block; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  2N  unsigned product from the multiplier
- in_valid  input  1  single-cycle pulse, in_data valid
- clear  input  1  synchronous abort of the current block
- in_ready  output  1  combinational; low means the next product would be dropped
- out_sum  output  ACC_W  block sum, ACC_W = 2N + LOG2LEN
- out_valid  output  1  out_sum holds an unconsumed block
- out_ready  input  1  downstream accepts out_sum when out_valid && out_ready
- drop_err  output  1  sticky, a completed block was discarded

Behaviour:
- Reset (rst=1 at posedge):
  - acc=0, cnt=0, out_sum=0, out_valid=0, drop_err=0.
  - Reset has priority over every other input.
  - Reset during a partial block discards it.
- Accumulate:
  - An in_valid cycle with cnt<LEN-1 does acc<=acc+in_data and cnt<=cnt+1.
  - acc is ACC_W bits wide, unsigned, and cannot overflow: LEN*(2^2N-1) < 2^ACC_W.
- Block completion: in_valid with cnt==LEN-1, called the last beat. What happens depends on the output register.
  - Output free (out_valid==0, or out_ready==1 in the same cycle):
    - out_sum <= acc+in_data; out_valid <= 1.
    - acc <= 0; cnt <= 0.
    - Latency from last in_valid to out_valid is 1 cycle.
  - Output busy (out_valid==1 and out_ready==0):
    - out_sum is kept; the new sum is discarded.
    - drop_err <= 1; acc <= 0; cnt <= 0.
- Output handshake:
  - out_valid clears on a cycle with out_valid && out_ready, unless a last beat loads a new sum in that same cycle, in which case it stays 1.
  - out_sum is stable while out_valid && !out_ready.
- in_ready = !(cnt==LEN-1 && out_valid && !out_ready). Control must not pulse the multiplier's start while in_ready is low.
- in_valid while in_ready is low follows the busy rule above.
- clear:
  - Sets acc<=0 and cnt<=0.
  - Leaves out_sum, out_valid and drop_err untouched.
  - clear with simultaneous in_valid: clear wins and the product is discarded.
- drop_err clears only on rst.
- No other state machine: cnt is the block phase, running 0..LEN-1 and wrapping to 0 on the last beat.

Optional Feature:
- MUL_ACC_AVG_EN defined:
  - out_sum is loaded with (acc+in_data) >> LOG2LEN, zero-extended to ACC_W, giving the block mean (truncating).
  - Handshake and error behaviour are unchanged.
- MUL_ACC_AVG_EN undefined: out_sum is the full block sum.

Decomposition:
- Shared package/header holds:
  - localparams ACC_W and LOG2LEN, computed with a clog2 function there;
  - the product-width constant PROD_W = 2N, shared with the multiplier.
- Natural sub-module: mul_acc_outreg.
  - Contains the out_sum/out_valid holding register, its ready handshake and the drop_err logic.
  - Interface: load strobe and data in; out_valid, out_ready and drop_err.
- Accumulator and counter stay in the top level.

Test Plan (N=4, LEN=4):
- Reset then 4 pulses of 15, 225, 1, 0 with out_ready=1 -> one cycle after the 4th pulse out_valid=1, out_sum=241; acc/cnt back to 0.
- 4 pulses of 225 -> out_sum=900, with no overflow at ACC_W=10. With MUL_ACC_AVG_EN -> out_sum=225; with 15, 225, 1, 0 -> out_sum=60.
- out_ready=0 and block sum 241 held; next block 4×1:
  - in_ready drops at cnt==3;
  - 4th pulse -> drop_err=1, out_sum stays 241;
  - out_ready=1 -> handshake completes, out_valid=0.
- Back-to-back: handshake in the same cycle as the next last beat -> out_valid stays 1 and out_sum updates to the new sum, with no drop_err.
- 2 pulses of 100, then clear, then 4 pulses of 10 -> out_sum=40. clear coincident with in_valid=7 -> product ignored.
- rst asserted at cnt==2 with out_valid=1 -> next cycle: all outputs 0, drop_err=0.
